// File: rtl/geofence_pkg.sv
// Shared types and sizing helpers for the polygon geofence engine.
// Combinational only; no latency or backpressure of its own.
package geofence_pkg;

   typedef enum logic [1:0] {
      LOAD,
      SORT,
      CHECK,
      DONE
   } state_t;

   // Compares needed to bubble-sort v2..vN around anchor v1.
   function automatic int sort_cycles(input int n);
      return (n - 2) * (n - 1) / 2;
   endfunction

   // W-bit unsigned coordinates: (W+1)-bit deltas, (2W+2)-bit products, one more bit for the difference.
   function automatic int cross_w(input int w);
      return 2 * w + 3;
   endfunction

endpackage

// File: rtl/geofence_cross.sv
// Signed cross product (B-A)x(C-A) of three unsigned points, zero-extended to avoid overflow.
// Purely combinational: zero latency, no backpressure.
module geofence_cross
   import geofence_pkg::*;
#(
   parameter int W = 10
) (
   input  logic [W-1:0]                ax,
   input  logic [W-1:0]                ay,
   input  logic [W-1:0]                bx,
   input  logic [W-1:0]                by,
   input  logic [W-1:0]                cx,
   input  logic [W-1:0]                cy,
   output logic signed [cross_w(W)-1:0] res
);

   logic signed [W:0]     dbx, dby, dcx, dcy;
   logic signed [2*W+1:0] p0, p1;

   always_comb begin
      dbx = $signed({1'b0, bx}) - $signed({1'b0, ax});
      dby = $signed({1'b0, by}) - $signed({1'b0, ay});
      dcx = $signed({1'b0, cx}) - $signed({1'b0, ax});
      dcy = $signed({1'b0, cy}) - $signed({1'b0, ay});
      p0  = dbx * dcy;
      p1  = dcx * dby;
      res = $signed({p0[2*W+1], p0}) - $signed({p1[2*W+1], p1});
   end

endmodule

// File: rtl/geofence_poly.sv
// Point-in-polygon: loads P plus N_VERT vertices, sorts them CCW around v1, then tests every edge.
// Result SORT_CYCLES+N_VERT edges after vN; in_ready is low outside LOAD, so input stalls there.
module geofence_poly
   import geofence_pkg::*;
#(
   parameter int W      = 10,
   parameter int N_VERT = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   output logic         out_valid,
   output logic         is_inside,
   output logic         on_edge,
   output logic         busy
);

   localparam int IW = $clog2(N_VERT);
   localparam int CW = $clog2(N_VERT + 1);
   localparam int XW = cross_w(W);
   localparam logic [CW-1:0] LAST_LD   = CW'(N_VERT);
   localparam logic [IW-1:0] LAST_PASS = IW'(N_VERT - 3);
   localparam logic [IW-1:0] LAST_EDGE = IW'(N_VERT - 1);

   state_t state, state_nxt;

   logic [W-1:0]  px, py;
   logic [W-1:0]  vx [N_VERT];
   logic [W-1:0]  vy [N_VERT];
   logic [CW-1:0] ld_cnt;
   logic [IW-1:0] pass_cnt, idx_cnt, edge_cnt;
   logic          neg_seen, zero_seen;

   logic [IW-1:0]        sj, sj1, ek1;
   logic [W-1:0]         ax, ay, bx, by, cx, cy;
   logic signed [XW-1:0] c;
   logic                 hs, pass_end, sort_last, edge_last, c_neg, c_zero;

   always_comb begin
      hs        = in_valid & in_ready;
      // Pass p (0-based here) ends at index N-3-p, so the final compare of the sort is pass N-3, index 0.
      pass_end  = (idx_cnt == (LAST_PASS - pass_cnt));
      sort_last = pass_end && (pass_cnt == LAST_PASS);
      edge_last = (edge_cnt == LAST_EDGE);
      sj        = idx_cnt + IW'(1);
      sj1       = idx_cnt + IW'(2);
      ek1       = edge_last ? '0 : edge_cnt + IW'(1);
      c_neg     = c[XW-1];
      c_zero    = (c == '0);
   end

   // SORT asks cross(v1, vj, vj+1); CHECK asks cross(P, vk, vk+1), which equals (vk-P)x(vk+1-vk).
   always_comb begin
      ax = px;
      ay = py;
      bx = vx[edge_cnt];
      by = vy[edge_cnt];
      cx = vx[ek1];
      cy = vy[ek1];
      if (state == SORT) begin
         ax = vx[0];
         ay = vy[0];
         bx = vx[sj];
         by = vy[sj];
         cx = vx[sj1];
         cy = vy[sj1];
      end
   end

   geofence_cross #(.W(W)) u_cross (
      .ax  (ax),
      .ay  (ay),
      .bx  (bx),
      .by  (by),
      .cx  (cx),
      .cy  (cy),
      .res (c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LOAD;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD:  if (hs && ld_cnt == LAST_LD) state_nxt = SORT;
         SORT:  if (sort_last)               state_nxt = CHECK;
         CHECK: if (edge_last)               state_nxt = DONE;
         DONE:                               state_nxt = LOAD;
         default:                            state_nxt = LOAD;
      endcase
   end

   always_comb begin
      in_ready = (state == LOAD);
      busy     = (state != LOAD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_cnt    <= '0;
         pass_cnt  <= '0;
         idx_cnt   <= '0;
         edge_cnt  <= '0;
         neg_seen  <= 1'b0;
         zero_seen <= 1'b0;
         out_valid <= 1'b0;
         is_inside <= 1'b0;
         on_edge   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            LOAD: if (hs) ld_cnt <= (ld_cnt == LAST_LD) ? '0 : ld_cnt + CW'(1);
            SORT: begin
               if (pass_end) begin
                  idx_cnt  <= '0;
                  pass_cnt <= sort_last ? '0 : pass_cnt + IW'(1);
               end else begin
                  idx_cnt  <= idx_cnt + IW'(1);
               end
            end
            CHECK: begin
               neg_seen  <= neg_seen | c_neg;
               zero_seen <= zero_seen | c_zero;
               edge_cnt  <= ek1;
               if (edge_last) begin
                  out_valid <= 1'b1;
                  is_inside <= !(neg_seen | c_neg);
                  on_edge   <= !(neg_seen | c_neg) & (zero_seen | c_zero);
               end
            end
            DONE: begin
               neg_seen  <= 1'b0;
               zero_seen <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Point storage carries no reset; every frame rewrites all of it before use.
   always_ff @(posedge clk) begin
      if (hs) begin
         if (ld_cnt == '0) begin
            px <= X;
            py <= Y;
         end
         for (int i = 0; i < N_VERT; i++) begin
            if (ld_cnt == CW'(i + 1)) begin
               vx[i] <= X;
               vy[i] <= Y;
            end
         end
      end else if (state == SORT && c_neg) begin
         vx[sj]  <= vx[sj1];
         vy[sj]  <= vy[sj1];
         vx[sj1] <= vx[sj];
         vy[sj1] <= vy[sj];
      end
   end

endmodule
